// File: rtl/conv10_seq_pkg.sv
// Shared types, layer encodings and width helpers for the conv10 sequencer.
`timescale 1ns/1ps
package conv10_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CLR,
        WB,
        DONE
    } state_t;

    localparam logic LAYER_CONV10_1 = 1'b0;
    localparam logic LAYER_CONV10_2 = 1'b1;

    // Never returns zero so a degenerate count of 1 still yields a legal vector.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int addr_w(input int wout, input int chin);
        return clog2_min1(wout * wout * chin);
    endfunction

    function automatic int pix_w(input int wout);
        return clog2_min1(wout * wout);
    endfunction

endpackage

// File: rtl/conv10_addr_gen.sv
// Pixel/channel counters and the registered IFM address pix*CHIN+ch.
`timescale 1ns/1ps
module conv10_addr_gen
    import conv10_seq_pkg::*;
#(
    parameter int WOUT   = 8,
    parameter int CHIN   = 736,
    parameter int ADDR_W = addr_w(WOUT, CHIN),
    parameter int PIX_W  = pix_w(WOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              ch_inc,
    input  logic              pix_inc,
    output logic              ch_last,
    output logic              pix_last,
    output logic [PIX_W-1:0]  pix,
    output logic [ADDR_W-1:0] addr
);

    localparam int CH_W = clog2_min1(CHIN);

    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign ch_last  = (ch_q == CH_W'(CHIN - 1));
    assign pix_last = (pix_q == PIX_W'(WOUT * WOUT - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ch_d  = ch_q;
        pix_d = pix_q;
        if (clear) begin
            ch_d  = '0;
            pix_d = '0;
        end else begin
            if (ch_inc) begin
                ch_d = ch_last ? '0 : ch_q + CH_W'(1);
            end
            if (pix_inc) begin
                pix_d = pix_last ? '0 : pix_q + PIX_W'(1);
            end
        end
        // Address follows the next counter values so it lines up with the registered strobes.
        addr_d = ADDR_W'(pix_d) * ADDR_W'(CHIN) + ADDR_W'(ch_d);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q   <= '0;
            pix_q  <= '0;
            addr_q <= '0;
        end else begin
            ch_q   <= ch_d;
            pix_q  <= pix_d;
            addr_q <= addr_d;
        end
    end

    assign pix  = pix_q;
    assign addr = addr_q;

endmodule

// File: rtl/conv10_seq_ctrl.sv
// Sequencer running conv10_1 then conv10_2 over the shared MAC array, pixel by pixel.
`timescale 1ns/1ps
module conv10_seq_ctrl
    import conv10_seq_pkg::*;
#(
    parameter int WOUT     = 8,
    parameter int CHIN     = 736,
    parameter int PIPE_LAT = 2,
    parameter int ADDR_W   = addr_w(WOUT, CHIN),
    parameter int PIX_W    = pix_w(WOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wb_ack,
    output logic              conv10_1_en,
    output logic              conv10_2_en,
    output logic              ifm_rd_en,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic              mac_clr,
    output logic              ofm_wr_en,
    output logic [PIX_W-1:0]  ofm_wr_addr,
    output logic              ofm_bank,
    output logic              busy,
    output logic              done
);

    localparam int DR_W = clog2_min1(PIPE_LAT);

    state_t          state_q, state_d;
    logic            layer_q, layer_d;
    logic [DR_W-1:0] drain_q, drain_d;

    logic clear, ch_inc, pix_inc, ch_last, pix_last;
    logic busy_q, done_q, c1_en_q, c2_en_q, rd_en_q, clr_q;

    conv10_addr_gen #(
        .WOUT   (WOUT),
        .CHIN   (CHIN),
        .ADDR_W (ADDR_W),
        .PIX_W  (PIX_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .ch_inc   (ch_inc),
        .pix_inc  (pix_inc),
        .ch_last  (ch_last),
        .pix_last (pix_last),
        .pix      (ofm_wr_addr),
        .addr     (ifm_addr)
    );

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        drain_d = drain_q;
        clear   = 1'b0;
        ch_inc  = 1'b0;
        pix_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    layer_d = LAYER_CONV10_1;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                ch_inc = 1'b1;
                if (ch_last) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DR_W'(PIPE_LAT - 1)) state_d = CLR;
                else                                 drain_d = drain_q + DR_W'(1);
            end
            CLR: state_d = WB;
            WB: begin
                // The final pixel of conv10_1 wraps pix to 0 and hands over to conv10_2.
                if (wb_ack) begin
                    if (!pix_last || layer_q == LAYER_CONV10_1) begin
                        pix_inc = 1'b1;
                        state_d = RUN;
                        if (pix_last) layer_d = LAYER_CONV10_2;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            layer_q <= LAYER_CONV10_1;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c1_en_q <= 1'b0;
            c2_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            drain_q <= drain_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            c1_en_q <= (state_d == RUN || state_d == DRAIN) && layer_d == LAYER_CONV10_1;
            c2_en_q <= (state_d == RUN || state_d == DRAIN) && layer_d == LAYER_CONV10_2;
            rd_en_q <= (state_d == RUN);
            clr_q   <= (state_d == CLR);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign conv10_1_en = c1_en_q;
    assign conv10_2_en = c2_en_q;
    assign ifm_rd_en   = rd_en_q;
    assign mac_clr     = clr_q;
    assign ofm_wr_en   = clr_q;
    assign ofm_bank    = layer_q;

endmodule
